control_unit: RTL and testbench

- Hardwired Moore control sequencer for the Mini SRC single-bus datapath.
- Steps the datapath through fetch (T0-T3) and per-opcode execute steps (T4-T9).
- Drives every datapath control input: register select/enable, bus-out, load, memory, I/O and ALU opcode.
- Sits beside the datapath in the CPU top level; takes IR and CON_FF back from the datapath.

---
 rtl/cu_pkg.sv | 83 ++++++++
 rtl/cu_decode.sv | 32 +++
 rtl/control_unit.sv | 210 +++++++++++++++++++++
 tb/tb_control_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared opcodes, mode/step encodings, opcode classes and control-word layout
// for the Mini SRC hardwired control unit.
package cu_pkg;

  localparam int OP_W = 5;
  localparam int ST_W = 4;

  typedef logic [OP_W-1:0] op_t;
  typedef logic [ST_W-1:0] step_t;

  localparam op_t OP_LD   = 5'd0;
  localparam op_t OP_LDI  = 5'd1;
  localparam op_t OP_ST   = 5'd2;
  localparam op_t OP_ADD  = 5'd3;
  localparam op_t OP_SUB  = 5'd4;
  localparam op_t OP_AND  = 5'd5;
  localparam op_t OP_OR   = 5'd6;
  localparam op_t OP_SHR  = 5'd7;
  localparam op_t OP_SHRA = 5'd8;
  localparam op_t OP_SHL  = 5'd9;
  localparam op_t OP_ROR  = 5'd10;
  localparam op_t OP_ROL  = 5'd11;
  localparam op_t OP_ADDI = 5'd12;
  localparam op_t OP_ANDI = 5'd13;
  localparam op_t OP_ORI  = 5'd14;
  localparam op_t OP_MUL  = 5'd15;
  localparam op_t OP_DIV  = 5'd16;
  localparam op_t OP_NEG  = 5'd17;
  localparam op_t OP_NOT  = 5'd18;
  localparam op_t OP_BR   = 5'd19;
  localparam op_t OP_JR   = 5'd20;
  localparam op_t OP_JAL  = 5'd21;
  localparam op_t OP_IN   = 5'd22;
  localparam op_t OP_OUT  = 5'd23;
  localparam op_t OP_MFHI = 5'd24;
  localparam op_t OP_MFLO = 5'd25;
  localparam op_t OP_NOP  = 5'd26;
  localparam op_t OP_HALT = 5'd27;

  localparam step_t T0 = 4'd0;
  localparam step_t T1 = 4'd1;
  localparam step_t T2 = 4'd2;
  localparam step_t T3 = 4'd3;
  localparam step_t T4 = 4'd4;
  localparam step_t T5 = 4'd5;
  localparam step_t T6 = 4'd6;
  localparam step_t T7 = 4'd7;
  localparam step_t T8 = 4'd8;
  localparam step_t T9 = 4'd9;

  typedef enum logic [1:0] {
    M_RESET = 2'd0,
    M_RUN   = 2'd1,
    M_HALT  = 2'd2
  } mode_t;

  typedef enum logic [3:0] {
    C_NOP, C_ALU_RR, C_ALU_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_UNARY,
    C_BR, C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT
  } cls_t;

  // Field order matches the port concatenation in control_unit.
  typedef struct packed {
    logic gra, grb, grc, rin, rout, baout;
    logic yin, zin, zhighout, zlowout, hiin, hiout, loin, loout;
    logic pcin, pcout, incpc, irin;
    logic marin, mdrin, mdrout, read, memread, memwrite;
    logic inportout, outportin, conin, r15in;
    logic cout;
  } ctl_t;

  function automatic step_t last_step(cls_t c);
    case (c)
      C_ALU_RR, C_ALU_IMM, C_LDI: return T6;
      C_LD:                       return T9;
      C_ST:                       return T8;
      C_MULDIV, C_BR:             return T7;
      C_UNARY, C_JAL:             return T5;
      default:                    return T4;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode-to-class decoder; unknown opcodes fall into the nop class.
module cu_decode
  import cu_pkg::*;
(
  input  op_t  op,
  output cls_t cls
);

  always_comb begin
    cls = C_NOP;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
      OP_SHL, OP_ROR, OP_ROL:        cls = C_ALU_RR;
      OP_ADDI, OP_ANDI, OP_ORI:      cls = C_ALU_IMM;
      OP_LDI:                        cls = C_LDI;
      OP_LD:                         cls = C_LD;
      OP_ST:                         cls = C_ST;
      OP_MUL, OP_DIV:                cls = C_MULDIV;
      OP_NEG, OP_NOT:                cls = C_UNARY;
      OP_BR:                         cls = C_BR;
      OP_JR:                         cls = C_JR;
      OP_JAL:                        cls = C_JAL;
      OP_IN:                         cls = C_IN;
      OP_OUT:                        cls = C_OUT;
      OP_MFHI:                       cls = C_MFHI;
      OP_MFLO:                       cls = C_MFLO;
      OP_HALT:                       cls = C_HALT;
      default:                       cls = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the Mini SRC single-bus datapath.
// Optional single-step gating at T0 is enabled by defining CU_SINGLE_STEP_EN.
module control_unit
  import cu_pkg::*;
#(
  parameter int IR_W     = 32,
  parameter int OPCODE_W = OP_W,
  parameter int STEP_W   = ST_W
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [IR_W-1:0]     ir,
  input  logic                con_ff,
  input  logic                stop,
`ifdef CU_SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic                run,
  output logic                Gra, Grb, Grc, Rin, Rout, BAout,
  output logic                Yin, Zin, Zhighout, Zlowout, Hiin, Hiout, LOin, LOout,
  output logic                PCin, PCout, IncPC, IRin,
  output logic                MARin, MDRin, MDRout, Read, memRead, memWrite,
  output logic                InPortOut, OutPortIn, CONin, R15in,
  output logic                Cout,
  output logic [OPCODE_W-1:0] alu_op
);

  mode_t             mode_q, mode_n;
  logic [STEP_W-1:0] step_q, step_n;
  op_t               op_q, cur_op;
  cls_t              cls;
  ctl_t              ctl;
  op_t               alu;
  logic              active;
  logic              go_q;
  logic              unused_ir;

  assign unused_ir = ^ir[IR_W-OPCODE_W-1:0];

  // IR is written at the end of T3, so T4 decodes the live IR and later steps
  // use the copy captured at the T4 edge.
  assign cur_op = (step_q == T4) ? op_t'(ir[IR_W-1 -: OPCODE_W]) : op_q;

  cu_decode u_decode (.op(cur_op), .cls(cls));

`ifdef CU_SINGLE_STEP_EN
  logic go_n;
`else
  assign go_q = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      mode_q <= M_RESET;
      step_q <= '0;
      op_q   <= OP_NOP;
`ifdef CU_SINGLE_STEP_EN
      go_q   <= 1'b0;
`endif
    end else begin
      mode_q <= mode_n;
      step_q <= step_n;
      if (mode_q == M_RUN && step_q == T4) op_q <= cur_op;
`ifdef CU_SINGLE_STEP_EN
      go_q   <= go_n;
`endif
    end
  end

  always_comb begin
    mode_n = mode_q;
    step_n = step_q;
`ifdef CU_SINGLE_STEP_EN
    go_n   = go_q;
`endif
    case (mode_q)
      M_RESET: begin
        mode_n = M_RUN;
        step_n = '0;
      end
      M_RUN: begin
        if (step_q == T0) begin
          if (stop) begin
            mode_n = M_HALT;
          end else if (go_q) begin
            step_n = T1;
          end
`ifdef CU_SINGLE_STEP_EN
          else begin
            go_n = step;
          end
`endif
        end else if (step_q == T4 && cls == C_HALT) begin
          mode_n = M_HALT;
          step_n = '0;
        end else if (step_q >= T4 && step_q == last_step(cls)) begin
          step_n = '0;
`ifdef CU_SINGLE_STEP_EN
          go_n   = 1'b0;
`endif
        end else begin
          step_n = step_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A waiting T0 (single-step build) behaves like an idle state: nothing driven.
  assign active = (mode_q == M_RUN) && (go_q || step_q != T0);

  always_comb begin
    ctl = '0;
    alu = active ? OP_ADD : '0;
    if (active) begin
      case (step_q)
        T0: begin ctl.pcout = 1'b1; ctl.marin = 1'b1; ctl.incpc = 1'b1; ctl.zin = 1'b1; end
        T1: begin ctl.zlowout = 1'b1; ctl.pcin = 1'b1; ctl.memread = 1'b1; end
        T2: begin ctl.memread = 1'b1; ctl.read = 1'b1; ctl.mdrin = 1'b1; end
        T3: begin ctl.mdrout = 1'b1; ctl.irin = 1'b1; end
        default: begin
          case (cls)
            C_ALU_RR, C_ALU_IMM: begin
              case (step_q)
                T4: begin ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.yin = 1'b1; end
                T5: begin
                  ctl.zin = 1'b1;
                  alu     = cur_op;
                  if (cls == C_ALU_IMM) ctl.cout = 1'b1;
                  else begin ctl.grc = 1'b1; ctl.rout = 1'b1; end
                end
                T6: begin ctl.zlowout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
                default: ;
              endcase
            end
            C_LDI, C_LD, C_ST: begin
              case (step_q)
                T4: begin ctl.grb = 1'b1; ctl.baout = 1'b1; ctl.yin = 1'b1; end
                T5: begin ctl.cout = 1'b1; ctl.zin = 1'b1; end
                T6: begin
                  ctl.zlowout = 1'b1;
                  if (cls == C_LDI) begin ctl.gra = 1'b1; ctl.rin = 1'b1; end
                  else ctl.marin = 1'b1;
                end
                T7: begin
                  if (cls == C_LD) ctl.memread = 1'b1;
                  if (cls == C_ST) begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.mdrin = 1'b1; end
                end
                T8: begin
                  if (cls == C_LD) begin ctl.memread = 1'b1; ctl.read = 1'b1; ctl.mdrin = 1'b1; end
                  if (cls == C_ST) ctl.memwrite = 1'b1;
                end
                T9: if (cls == C_LD) begin ctl.mdrout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
                default: ;
              endcase
            end
            C_MULDIV: begin
              case (step_q)
                T4: begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.yin = 1'b1; end
                T5: begin ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.zin = 1'b1; alu = cur_op; end
                T6: begin ctl.zlowout = 1'b1; ctl.loin = 1'b1; end
                T7: begin ctl.zhighout = 1'b1; ctl.hiin = 1'b1; end
                default: ;
              endcase
            end
            C_UNARY: begin
              case (step_q)
                T4: begin ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.zin = 1'b1; alu = cur_op; end
                T5: begin ctl.zlowout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
                default: ;
              endcase
            end
            C_BR: begin
              case (step_q)
                T4: begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.conin = 1'b1; end
                T5: begin ctl.pcout = 1'b1; ctl.yin = 1'b1; end
                T6: begin ctl.cout = 1'b1; ctl.zin = 1'b1; end
                T7: begin ctl.zlowout = 1'b1; ctl.pcin = con_ff; end
                default: ;
              endcase
            end
            C_JR: if (step_q == T4) begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.pcin = 1'b1; end
            C_JAL: begin
              if (step_q == T4) begin ctl.pcout = 1'b1; ctl.r15in = 1'b1; end
              if (step_q == T5) begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.pcin = 1'b1; end
            end
            C_IN:   if (step_q == T4) begin ctl.inportout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
            C_OUT:  if (step_q == T4) begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.outportin = 1'b1; end
            C_MFHI: if (step_q == T4) begin ctl.hiout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
            C_MFLO: if (step_q == T4) begin ctl.loout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
            default: ;
          endcase
        end
      endcase
    end
  end

  assign run    = (mode_q == M_RUN);
  assign alu_op = OPCODE_W'(alu);
  assign {Gra, Grb, Grc, Rin, Rout, BAout,
          Yin, Zin, Zhighout, Zlowout, Hiin, Hiout, LOin, LOout,
          PCin, PCout, IncPC, IRin,
          MARin, MDRin, MDRout, Read, memRead, memWrite,
          InPortOut, OutPortIn, CONin, R15in, Cout} = ctl;

  a_one_bus_driver: assert property (@(posedge clock) disable iff (clear)
    $onehot0({ctl.rout, ctl.baout, ctl.zhighout, ctl.zlowout, ctl.hiout,
              ctl.loout, ctl.pcout, ctl.mdrout, ctl.inportout, ctl.cout}));

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: each instruction's expected step
// sequence is built from the opcode's micro-step list and compared per cycle.
module tb_control_unit;

  typedef logic [28:0] sig_t;

  localparam sig_t GRA   = sig_t'(1) << 28, GRB   = sig_t'(1) << 27, GRC   = sig_t'(1) << 26;
  localparam sig_t RIN   = sig_t'(1) << 25, ROUT  = sig_t'(1) << 24, BAOUT = sig_t'(1) << 23;
  localparam sig_t YIN   = sig_t'(1) << 22, ZIN   = sig_t'(1) << 21, ZHI   = sig_t'(1) << 20;
  localparam sig_t ZLO   = sig_t'(1) << 19, HIIN  = sig_t'(1) << 18, HIOUT = sig_t'(1) << 17;
  localparam sig_t LOIN  = sig_t'(1) << 16, LOOUT = sig_t'(1) << 15, PCIN  = sig_t'(1) << 14;
  localparam sig_t PCOUT = sig_t'(1) << 13, INCPC = sig_t'(1) << 12, IRIN  = sig_t'(1) << 11;
  localparam sig_t MARIN = sig_t'(1) << 10, MDRIN = sig_t'(1) << 9,  MDROUT = sig_t'(1) << 8;
  localparam sig_t READ  = sig_t'(1) << 7,  MEMRD = sig_t'(1) << 6,  MEMWR = sig_t'(1) << 5;
  localparam sig_t INP   = sig_t'(1) << 4,  OUTP  = sig_t'(1) << 3,  CONIN = sig_t'(1) << 2;
  localparam sig_t R15IN = sig_t'(1) << 1,  COUT  = sig_t'(1) << 0;

  logic clock, clear, con_ff, stop, step, run;
  logic [31:0] ir;
  logic [4:0]  alu_op;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Yin, Zin, Zhighout, Zlowout, Hiin, Hiout, LOin, LOout;
  logic PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout, Read, memRead, memWrite;
  logic InPortOut, OutPortIn, CONin, R15in, Cout;
  sig_t obs;

  assign obs = {Gra, Grb, Grc, Rin, Rout, BAout, Yin, Zin, Zhighout, Zlowout, Hiin, Hiout,
                LOin, LOout, PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout, Read, memRead,
                memWrite, InPortOut, OutPortIn, CONin, R15in, Cout};

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop),
`ifdef CU_SINGLE_STEP_EN
    .step(step),
`endif
    .run(run), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout), .Hiin(Hiin), .Hiout(Hiout),
    .LOin(LOin), .LOout(LOout), .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .IRin(IRin),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .memRead(memRead),
    .memWrite(memWrite), .InPortOut(InPortOut), .OutPortIn(OutPortIn), .CONin(CONin),
    .R15in(R15in), .Cout(Cout), .alu_op(alu_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   n_cmp = 0, n_fail = 0;
  sig_t mseq[$];
  int   malu;
  sig_t exp_s;
  logic [4:0] exp_a;

  function automatic sig_t fetch_sig(int t);
    case (t)
      0: return PCOUT | MARIN | INCPC | ZIN;
      1: return ZLO | PCIN | MEMRD;
      2: return MEMRD | READ | MDRIN;
      default: return MDROUT | IRIN;
    endcase
  endfunction

  // Execute-step list (T4 onward) and the absolute step carrying the opcode to the ALU.
  function automatic void build(int op, bit cf);
    mseq.delete();
    malu = -1;
    if (op inside {[3:11]}) begin
      mseq.push_back(GRB|ROUT|YIN); mseq.push_back(GRC|ROUT|ZIN); mseq.push_back(ZLO|GRA|RIN); malu = 5;
    end else if (op inside {[12:14]}) begin
      mseq.push_back(GRB|ROUT|YIN); mseq.push_back(COUT|ZIN); mseq.push_back(ZLO|GRA|RIN); malu = 5;
    end else if (op == 1) begin
      mseq.push_back(GRB|BAOUT|YIN); mseq.push_back(COUT|ZIN); mseq.push_back(ZLO|GRA|RIN);
    end else if (op == 0 || op == 2) begin
      mseq.push_back(GRB|BAOUT|YIN); mseq.push_back(COUT|ZIN); mseq.push_back(ZLO|MARIN);
      if (op == 0) begin
        mseq.push_back(MEMRD); mseq.push_back(MEMRD|READ|MDRIN); mseq.push_back(MDROUT|GRA|RIN);
      end else begin
        mseq.push_back(GRA|ROUT|MDRIN); mseq.push_back(MEMWR);
      end
    end else if (op == 15 || op == 16) begin
      mseq.push_back(GRA|ROUT|YIN); mseq.push_back(GRB|ROUT|ZIN);
      mseq.push_back(ZLO|LOIN); mseq.push_back(ZHI|HIIN); malu = 5;
    end else if (op == 17 || op == 18) begin
      mseq.push_back(GRB|ROUT|ZIN); mseq.push_back(ZLO|GRA|RIN); malu = 4;
    end else if (op == 19) begin
      mseq.push_back(GRA|ROUT|CONIN); mseq.push_back(PCOUT|YIN); mseq.push_back(COUT|ZIN);
      mseq.push_back(cf ? (ZLO|PCIN) : ZLO);
    end else if (op == 20) mseq.push_back(GRA|ROUT|PCIN);
    else if (op == 21) begin mseq.push_back(PCOUT|R15IN); mseq.push_back(GRA|ROUT|PCIN); end
    else if (op == 22) mseq.push_back(INP|GRA|RIN);
    else if (op == 23) mseq.push_back(GRA|ROUT|OUTP);
    else if (op == 24) mseq.push_back(HIOUT|GRA|RIN);
    else if (op == 25) mseq.push_back(LOOUT|GRA|RIN);
    else mseq.push_back('0);
  endfunction

  task automatic test_reset();
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); @(negedge clock);
      n_cmp++;
      if (obs !== '0 || run !== 1'b0 || alu_op !== 5'd0) begin
        n_fail++;
        $display("FAIL reset_hold c%0d: got ctl=%h run=%b alu=%0d, want 0/0/0", i, obs, run, alu_op);
      end
    end
    clear = 1'b0;
    @(posedge clock); @(negedge clock);
    n_cmp++;
    if (obs !== fetch_sig(0) || run !== 1'b1 || alu_op !== 5'd3) begin
      n_fail++;
      $display("FAIL reset_release: got ctl=%h run=%b alu=%0d, want %h/1/3", obs, run, alu_op, fetch_sig(0));
    end
  endtask

  task automatic test_add();
    int op = 3;
    ir = {5'd3, 4'd1, 4'd2, 4'd3, 15'd0};
    build(op, 1'b0);
    for (int t = 0; t < 4 + mseq.size(); t++) begin
      exp_s = (t < 4) ? fetch_sig(t) : mseq[t-4];
      exp_a = (t == malu) ? 5'(op) : 5'd3;
      n_cmp++;
      if (obs !== exp_s || alu_op !== exp_a || run !== 1'b1) begin
        n_fail++;
        $display("FAIL add T%0d: got ctl=%h alu=%0d run=%b, want ctl=%h alu=%0d run=1", t, obs, alu_op, run, exp_s, exp_a);
      end
      @(posedge clock); @(negedge clock);
    end
    n_cmp++;
    if (obs !== fetch_sig(0) || run !== 1'b1) begin
      n_fail++;
      $display("FAIL add_len7: got ctl=%h run=%b, want T0 %h", obs, run, fetch_sig(0));
    end
  endtask

  task automatic test_ld();
    int op = 0;
    ir = {5'd0, 4'd1, 4'd0, 19'h55};
    build(op, 1'b0);
    for (int t = 0; t < 4 + mseq.size(); t++) begin
      exp_s = (t < 4) ? fetch_sig(t) : mseq[t-4];
      n_cmp++;
      if (obs !== exp_s || alu_op !== 5'd3 || run !== 1'b1) begin
        n_fail++;
        $display("FAIL ld T%0d: got ctl=%h alu=%0d run=%b, want ctl=%h alu=3 run=1", t, obs, alu_op, run, exp_s);
      end
      @(posedge clock); @(negedge clock);
    end
    n_cmp++;
    if (obs !== fetch_sig(0) || run !== 1'b1) begin
      n_fail++;
      $display("FAIL ld_len10: got ctl=%h run=%b, want T0 %h", obs, run, fetch_sig(0));
    end
  endtask

  task automatic test_br();
    int op = 19;
    for (int c = 0; c < 2; c++) begin
      ir = {5'd19, 4'd2, 4'd1, 19'h7};
      con_ff = c[0];
      build(op, c[0]);
      for (int t = 0; t < 4 + mseq.size(); t++) begin
        exp_s = (t < 4) ? fetch_sig(t) : mseq[t-4];
        n_cmp++;
        if (obs !== exp_s || alu_op !== 5'd3) begin
          n_fail++;
          $display("FAIL br_cf%0d T%0d: got ctl=%h alu=%0d, want ctl=%h alu=3", c, t, obs, alu_op, exp_s);
        end
        @(posedge clock); @(negedge clock);
      end
    end
    con_ff = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++) begin
      int op = int'($urandom_range(31, 0));
      if (op == 27) op = 26;
      con_ff = 1'($urandom);
      ir = {5'(op), 27'($urandom)};
      build(op, con_ff);
      for (int t = 0; t < 4 + mseq.size(); t++) begin
        exp_s = (t < 4) ? fetch_sig(t) : mseq[t-4];
        exp_a = (t == malu) ? 5'(op) : 5'd3;
        n_cmp++;
        if (obs !== exp_s || alu_op !== exp_a || run !== 1'b1) begin
          n_fail++;
          $display("FAIL rand op%0d T%0d: got ctl=%h alu=%0d run=%b, want ctl=%h alu=%0d run=1", op, t, obs, alu_op, run, exp_s, exp_a);
        end
        @(posedge clock); @(negedge clock);
      end
    end
    con_ff = 1'b0;
  endtask

  task automatic test_clear_mid();
    ir = {5'd0, 4'd3, 4'd4, 19'h12};
    repeat (6) begin @(posedge clock); @(negedge clock); end
    n_cmp++;
    if (obs !== (ZLO | MARIN)) begin
      n_fail++;
      $display("FAIL clear_mid_T6: got ctl=%h, want %h", obs, ZLO | MARIN);
    end
    clear = 1'b1;
    @(posedge clock); @(negedge clock);
    n_cmp++;
    if (obs !== '0 || run !== 1'b0 || alu_op !== 5'd0) begin
      n_fail++;
      $display("FAIL clear_mid_reset: got ctl=%h run=%b alu=%0d, want 0/0/0", obs, run, alu_op);
    end
    clear = 1'b0;
    ir = {5'd26, 27'd0};
    @(posedge clock); @(negedge clock);
    for (int t = 0; t < 5; t++) begin
      exp_s = (t < 4) ? fetch_sig(t) : '0;
      n_cmp++;
      if (obs !== exp_s || run !== 1'b1 || alu_op !== 5'd3) begin
        n_fail++;
        $display("FAIL clear_mid_refetch T%0d: got ctl=%h run=%b alu=%0d, want %h/1/3", t, obs, run, alu_op, exp_s);
      end
      @(posedge clock); @(negedge clock);
    end
  endtask

  task automatic test_stop();
    stop = 1'b1;
    @(posedge clock); @(negedge clock);
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs !== '0 || run !== 1'b0 || alu_op !== 5'd0) begin
        n_fail++;
        $display("FAIL stop_halt c%0d: got ctl=%h run=%b alu=%0d, want 0/0/0", i, obs, run, alu_op);
      end
      @(posedge clock); @(negedge clock);
    end
    clear = 1'b1;
    @(posedge clock); @(negedge clock);
    clear = 1'b0;
    @(posedge clock); @(negedge clock);
  endtask

  task automatic test_halt();
    ir = {5'd27, 27'd0};
    for (int t = 0; t < 5; t++) begin
      exp_s = (t < 4) ? fetch_sig(t) : '0;
      n_cmp++;
      if (obs !== exp_s || run !== 1'b1) begin
        n_fail++;
        $display("FAIL halt T%0d: got ctl=%h run=%b, want %h/1", t, obs, run, exp_s);
      end
      @(posedge clock); @(negedge clock);
    end
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (obs !== '0 || run !== 1'b0 || alu_op !== 5'd0) begin
        n_fail++;
        $display("FAIL halt_hold c%0d: got ctl=%h run=%b alu=%0d, want 0/0/0", i, obs, run, alu_op);
      end
      @(posedge clock); @(negedge clock);
    end
  endtask

  task automatic test_single_step();
    ir = {5'd26, 27'd0};
    clear = 1'b1;
    repeat (2) begin @(posedge clock); @(negedge clock); end
    clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); @(negedge clock);
      n_cmp++;
      if (obs !== '0 || run !== 1'b1 || alu_op !== 5'd0) begin
        n_fail++;
        $display("FAIL step_wait c%0d: got ctl=%h run=%b alu=%0d, want 0/1/0", i, obs, run, alu_op);
      end
    end
    step = 1'b1;
    @(posedge clock); @(negedge clock);
    step = 1'b0;
    for (int t = 0; t < 5; t++) begin
      exp_s = (t < 4) ? fetch_sig(t) : '0;
      n_cmp++;
      if (obs !== exp_s || run !== 1'b1 || alu_op !== 5'd3) begin
        n_fail++;
        $display("FAIL step_nop T%0d: got ctl=%h run=%b alu=%0d, want %h/1/3", t, obs, run, alu_op, exp_s);
      end
      @(posedge clock); @(negedge clock);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (obs !== '0 || run !== 1'b1 || alu_op !== 5'd0) begin
        n_fail++;
        $display("FAIL step_rewait c%0d: got ctl=%h run=%b alu=%0d, want 0/1/0", i, obs, run, alu_op);
      end
      @(posedge clock); @(negedge clock);
    end
  endtask

  initial begin
    clear = 1'b1; stop = 1'b0; step = 1'b0; con_ff = 1'b0;
    ir = {5'd26, 27'd0};
`ifdef CU_SINGLE_STEP_EN
    test_single_step();
`else
    test_reset();
    test_add();
    test_ld();
    test_br();
    test_back_to_back();
    test_clear_mid();
    test_stop();
    test_halt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
